// File: rtl/cam_emulator.sv
// cam_emulator: emulates a QQVGA-class camera sensor emitting RGB444 frames.
//
// A free-running pixel clock (clk/2) is generated; all sensor-side outputs and the
// timing FSM advance only on "pclk ticks" (the clk edge where CAM_pclk falls), so
// they are stable whenever CAM_pclk rises. A frame is VSYNC, vertical back porch,
// WR lines of (2*WC bytes of ACTIVE + HBLANK), then vertical front porch.
//
// Configuration macro: CAM_EMU_COLORBAR_EN
//   undefined (default) : gradient pattern R=col[7:4], G=row[6:3], B=col[3:0]
//   defined             : 8 vertical colour bars, each WC/8 columns wide
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   enable       in   1 = generate frames continuously (sampled at frame boundaries)
//   CAM_pclk     out  emulated pixel clock, clk/2
//   CAM_vsync    out  frame sync, active-high
//   CAM_href     out  line valid, active-high
//   CAM_px_data  out  pixel byte; even byte {4'h0, R}, odd byte {G, B}; 0 outside href
//   frame_done   out  one-clk pulse when the last line's blanking ends

module cam_emulator #(
    parameter int WC      = 160,
    parameter int WR      = 120,
    parameter int VS_LEN  = 3,
    parameter int VBP_LEN = 17,
    parameter int HB_LEN  = 16,
    parameter int VFP_LEN = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    output logic       CAM_pclk,
    output logic       CAM_vsync,
    output logic       CAM_href,
    output logic [7:0] CAM_px_data,
    output logic       frame_done
);

    localparam int COL_W = ($clog2(WC) > 8) ? $clog2(WC) : 8;
    localparam int ROW_W = ($clog2(WR) > 7) ? $clog2(WR) : 7;
    localparam int CNT_W = 16;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WC - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(WR - 1);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(VS_LEN - 1);
    localparam logic [CNT_W-1:0] VBP_LAST = CNT_W'(VBP_LEN - 1);
    localparam logic [CNT_W-1:0] HB_LAST  = CNT_W'(HB_LEN - 1);
    localparam logic [CNT_W-1:0] VFP_LAST = CNT_W'(VFP_LEN - 1);

    typedef enum logic [2:0] {
        StIdle,
        StVsync,
        StVbp,
        StActive,
        StHblank,
        StVfp
    } state_t;

    state_t             state_q, state_d;
    logic               pclk_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic               phase_q, phase_d;   // 0 = first byte {0,R}, 1 = second byte {G,B}
    logic               frame_done_q, frame_done_d;

    logic [3:0] pix_r, pix_g, pix_b;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pclk_q       <= 1'b0;
            state_q      <= StIdle;
            cnt_q        <= '0;
            col_q        <= '0;
            row_q        <= '0;
            phase_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            pclk_q       <= ~pclk_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            col_q        <= col_d;
            row_q        <= row_d;
            phase_q      <= phase_d;
            frame_done_q <= frame_done_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; only evaluated on a pclk tick (pclk currently high,
    // about to fall), otherwise everything holds.
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        col_d        = col_q;
        row_d        = row_q;
        phase_d      = phase_q;
        frame_done_d = 1'b0;

        if (pclk_q) begin
            unique case (state_q)
                StIdle: begin
                    if (enable) begin
                        state_d = StVsync;
                        cnt_d   = '0;
                    end
                end
                StVsync: begin
                    if (cnt_q == VS_LAST) begin
                        state_d = StVbp;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StVbp: begin
                    if (cnt_q == VBP_LAST) begin
                        state_d = StActive;
                        cnt_d   = '0;
                        row_d   = '0;
                        col_d   = '0;
                        phase_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StActive: begin
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (col_q == COL_LAST) begin
                            state_d = StHblank;
                            col_d   = '0;
                            cnt_d   = '0;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end
                StHblank: begin
                    if (cnt_q == HB_LAST) begin
                        cnt_d = '0;
                        if (row_q == ROW_LAST) begin
                            state_d      = StVfp;
                            row_d        = '0;
                            frame_done_d = 1'b1;
                        end else begin
                            state_d = StActive;
                            row_d   = row_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StVfp: begin
                    // enable is only looked at here, so a frame is never cut short
                    if (cnt_q == VFP_LAST) begin
                        cnt_d   = '0;
                        state_d = enable ? StVsync : StIdle;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Pixel pattern
    // ------------------------------------------------------------------
`ifdef CAM_EMU_COLORBAR_EN
    localparam int BAR_W = (WC / 8 > 0) ? WC / 8 : 1;

    logic [COL_W-1:0] bar_full;
    logic [2:0]       bar_sel;

    always_comb begin
        bar_full = col_q / COL_W'(BAR_W);
        // Clamp so leftover columns (WC not a multiple of 8) extend the last bar
        bar_sel  = (bar_full > COL_W'(7)) ? 3'd7 : bar_full[2:0];
        unique case (bar_sel)
            3'd0:    {pix_r, pix_g, pix_b} = 12'hFFF;
            3'd1:    {pix_r, pix_g, pix_b} = 12'hFF0;
            3'd2:    {pix_r, pix_g, pix_b} = 12'h0FF;
            3'd3:    {pix_r, pix_g, pix_b} = 12'h0F0;
            3'd4:    {pix_r, pix_g, pix_b} = 12'hF0F;
            3'd5:    {pix_r, pix_g, pix_b} = 12'hF00;
            3'd6:    {pix_r, pix_g, pix_b} = 12'h00F;
            default: {pix_r, pix_g, pix_b} = 12'h000;
        endcase
    end
`else
    always_comb begin
        pix_r = col_q[7:4];
        pix_g = row_q[6:3];
        pix_b = col_q[3:0];
    end
`endif

    // ------------------------------------------------------------------
    // Outputs: decoded from registers, so they move only on pclk ticks
    // and clear immediately with the asynchronous reset.
    // ------------------------------------------------------------------
    always_comb begin
        CAM_pclk    = pclk_q;
        CAM_vsync   = (state_q == StVsync);
        CAM_href    = (state_q == StActive);
        CAM_px_data = 8'h00;
        if (state_q == StActive) begin
            CAM_px_data = phase_q ? {pix_g, pix_b} : {4'h0, pix_r};
        end
        frame_done  = frame_done_q;
    end

endmodule

// File: tb/tb_cam_emulator.sv
// Self-checking bench for cam_emulator (default parameters). Samples the camera
// bus on CAM_pclk rising edges, as a receiver would.

module tb_cam_emulator;

    localparam int WC = 160;
    localparam int WR = 120;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       CAM_pclk;
    logic       CAM_vsync;
    logic       CAM_href;
    logic [7:0] CAM_px_data;
    logic       frame_done;

    int n_checks = 0;
    int n_pass   = 0;
    int fd_cnt   = 0;

    cam_emulator dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .CAM_pclk    (CAM_pclk),
        .CAM_vsync   (CAM_vsync),
        .CAM_href    (CAM_href),
        .CAM_px_data (CAM_px_data),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance to the next CAM_pclk rising edge, then settle 1 time unit.
    task automatic next_rise();
        @(posedge clk);
        #1;
        if (CAM_pclk !== 1'b1) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference byte for line `row`, byte index `idx` within the line.
    function automatic logic [7:0] exp_byte(input int row, input int idx);
        logic [7:0]  c8;
        logic [7:0]  r8;
        logic [11:0] rgb;
        int          bar;
        c8 = 8'(idx / 2);
        r8 = 8'(row);
`ifdef CAM_EMU_COLORBAR_EN
        bar = (idx / 2) / (WC / 8);
        if (bar > 7) bar = 7;
        case (bar)
            0:       rgb = 12'hFFF;
            1:       rgb = 12'hFF0;
            2:       rgb = 12'h0FF;
            3:       rgb = 12'h0F0;
            4:       rgb = 12'hF0F;
            5:       rgb = 12'hF00;
            6:       rgb = 12'h00F;
            default: rgb = 12'h000;
        endcase
`else
        bar = 0;
        rgb = {c8[7:4], r8[6:3], c8[3:0]};
`endif
        if ((idx % 2) == 0) return {4'h0, rgb[11:8]};
        else return rgb[7:0];
    endfunction

    logic [7:0] line [0:399];

    initial begin
        int   found, early, vs_len, gap, len, prev;
        int   bad_tog, bad_quiet, bad_len, bad_pix, bad_gap, bad_blank, lines_ok;
        int   rises, hcount, prevh;

        rst    = 1'b1;
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pclk",  32'(CAM_pclk),    32'd0);
        chk("rst_vsync", 32'(CAM_vsync),   32'd0);
        chk("rst_href",  32'(CAM_href),    32'd0);
        chk("rst_px",    32'(CAM_px_data), 32'h00);
        chk("rst_fd",    32'(frame_done),  32'd0);

        // Idle with enable low: pclk toggles every clk, bus stays quiet
        @(negedge clk);
        rst       = 1'b0;
        prev      = 0;
        bad_tog   = 0;
        bad_quiet = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (int'(CAM_pclk) == prev || CAM_pclk === 1'bx) bad_tog++;
            prev = int'(CAM_pclk);
            if (CAM_vsync !== 1'b0 || CAM_href !== 1'b0 || CAM_px_data !== 8'h00 ||
                frame_done !== 1'b0) bad_quiet++;
        end
        chk("idle_pclk_toggle", 32'(bad_tog),   32'd0);
        chk("idle_quiet",       32'(bad_quiet), 32'd0);

        // Frame 1
        enable = 1'b1;
        found  = 0;
        early  = 0;
        for (int i = 0; i < 8; i++) begin
            next_rise();
            if (CAM_href !== 1'b0) early++;
            if (CAM_vsync === 1'b1) begin
                found = 1;
                break;
            end
        end
        chk("vsync_start", 32'(found), 32'd1);
        chk("href_before_vsync", 32'(early), 32'd0);
        vs_len = 0;
        while (CAM_vsync === 1'b1 && vs_len < 50) begin
            vs_len++;
            next_rise();
        end
        chk("vsync_len", 32'(vs_len), 32'd3);
        gap = 0;
        while (CAM_href !== 1'b1 && gap < 100) begin
            gap++;
            next_rise();
        end
        chk("vbp_len", 32'(gap), 32'd17);

        bad_len   = 0;
        bad_pix   = 0;
        bad_gap   = 0;
        bad_blank = 0;
        lines_ok  = 0;
        for (int r = 0; r < WR; r++) begin
            if (r == 50) enable = 1'b0;
            if (r == WR - 1) chk("fd_before_last_line", 32'(fd_cnt), 32'd0);
            len = 0;
            while (CAM_href === 1'b1 && len < 400) begin
                line[len] = CAM_px_data;
                len++;
                next_rise();
            end
            if (len != 2 * WC) bad_len++;
            else lines_ok++;
            for (int i = 0; i < len; i++) begin
                if (line[i] !== exp_byte(r, i)) bad_pix++;
            end
`ifdef CAM_EMU_COLORBAR_EN
            if (r == 8) begin
                chk("bar_col0_b0",   32'(line[0]),   32'h0F);
                chk("bar_col0_b1",   32'(line[1]),   32'hFF);
                chk("bar_col20_b0",  32'(line[40]),  32'h0F);
                chk("bar_col20_b1",  32'(line[41]),  32'hF0);
                chk("bar_col159_b0", 32'(line[318]), 32'h00);
                chk("bar_col159_b1", 32'(line[319]), 32'h00);
            end
`else
            if (r == 0) begin
                chk("r0_c0_b0", 32'(line[0]), 32'h00);
                chk("r0_c0_b1", 32'(line[1]), 32'h00);
            end
            if (r == 8) begin
                chk("r8_c17_b0", 32'(line[34]), 32'h01);
                chk("r8_c17_b1", 32'(line[35]), 32'h11);
            end
`endif
            if (r < WR - 1) begin
                gap = 0;
                while (CAM_href !== 1'b1 && gap < 100) begin
                    if (CAM_vsync !== 1'b0 || CAM_px_data !== 8'h00) bad_blank++;
                    gap++;
                    next_rise();
                end
                if (gap != 16) bad_gap++;
            end
        end
        chk("lines_full_len", 32'(lines_ok),  32'(WR));
        chk("line_len_bad",   32'(bad_len),   32'd0);
        chk("pixel_bad",      32'(bad_pix),   32'd0);
        chk("hblank_len_bad", 32'(bad_gap),   32'd0);
        chk("hblank_bus_bad", 32'(bad_blank), 32'd0);

        // VFP then IDLE (enable was dropped during row 50)
        bad_quiet = 0;
        for (int i = 0; i < 300; i++) begin
            if (CAM_vsync !== 1'b0 || CAM_href !== 1'b0 || CAM_px_data !== 8'h00) bad_quiet++;
            next_rise();
        end
        chk("post_frame_idle", 32'(bad_quiet), 32'd0);
        chk("frame_done_count", 32'(fd_cnt), 32'd1);

        // Frame 2: reset during row 10
        enable = 1'b1;
        rises  = 0;
        hcount = 0;
        prevh  = 0;
        while (hcount < 11 && rises < 8000) begin
            next_rise();
            rises++;
            if (CAM_href === 1'b1 && prevh == 0) hcount++;
            prevh = (CAM_href === 1'b1) ? 1 : 0;
        end
        chk("row10_reached", 32'(hcount), 32'd11);
        repeat (5) next_rise();
        chk("pre_rst_href", 32'(CAM_href),    32'd1);
        chk("pre_rst_byte", 32'(CAM_px_data), 32'(exp_byte(10, 5)));
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_pclk",  32'(CAM_pclk),    32'd0);
        chk("mid_rst_vsync", 32'(CAM_vsync),   32'd0);
        chk("mid_rst_href",  32'(CAM_href),    32'd0);
        chk("mid_rst_px",    32'(CAM_px_data), 32'h00);
        chk("mid_rst_fd",    32'(frame_done),  32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        found = 0;
        early = 0;
        for (int i = 0; i < 8; i++) begin
            next_rise();
            if (CAM_href !== 1'b0) early++;
            if (CAM_vsync === 1'b1) begin
                found = 1;
                break;
            end
        end
        chk("restart_vsync", 32'(found), 32'd1);
        chk("restart_href_early", 32'(early), 32'd0);
        vs_len = 0;
        while (CAM_vsync === 1'b1 && vs_len < 50) begin
            vs_len++;
            next_rise();
        end
        chk("restart_vsync_len", 32'(vs_len), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cam_emulator.md
CAM_EMULATOR -- requirements
Module: cam_emulator

Interface
REQ-001 Parameter WC, default 160, active pixels per line (QQVGA width).
REQ-002 Parameter WR, default 120, active lines per frame (QQVGA height).
REQ-003 Parameter VS_LEN, default 3, vsync-high duration in pclk periods.
REQ-004 Parameter VBP_LEN, default 17, vertical back porch in pclk periods.
REQ-005 Parameter HB_LEN, default 16, horizontal blank after each line in pclk periods.
REQ-006 Parameter VFP_LEN, default 10, vertical front porch in pclk periods.
REQ-007 clk  input  1  system clock; the block has one clock.
REQ-008 rst  input  1  reset; asynchronous, active-high.
REQ-009 enable  input  1  level; 1 = generate frames continuously.
REQ-010 CAM_pclk  output  1  emulated pixel clock, clk/2.
REQ-011 CAM_vsync  output  1  frame sync, active-high.
REQ-012 CAM_href  output  1  line valid, active-high.
REQ-013 CAM_px_data  output  8  pixel byte, RGB444 two-byte format.
REQ-014 frame_done  output  1  one-clk pulse at end of each frame's active region.

Function
REQ-015 CAM_pclk SHALL toggle on every clk rising edge while not in reset; "pclk tick" = clk edge on which CAM_pclk goes 1->0.
REQ-016 CAM_vsync, CAM_href, CAM_px_data and FSM state SHALL change only on pclk ticks, so that they are stable at every CAM_pclk rising edge.
REQ-017 FSM states: IDLE, VSYNC, VBP, ACTIVE, HBLANK, VFP.
REQ-018 IDLE -> VSYNC on the first pclk tick with enable=1.
REQ-019 VSYNC: CAM_vsync=1 for exactly VS_LEN pclk periods, then -> VBP.
REQ-020 VBP: all outputs low for VBP_LEN pclk periods, then -> ACTIVE with row=0.
REQ-021 ACTIVE: CAM_href=1 for exactly 2*WC pclk periods; byte 2k = {4'b0000, R}, byte 2k+1 = {G, B} for column k.
REQ-022 After ACTIVE -> HBLANK (href=0, px_data=0) for HB_LEN periods; then -> ACTIVE with row+1 if row<WR-1, else -> VFP.
REQ-023 On the last HBLANK->VFP transition, frame_done SHALL pulse high for exactly one clk.
REQ-024 VFP lasts VFP_LEN periods, then -> VSYNC if enable=1, else -> IDLE.
REQ-025 Deasserting enable mid-frame SHALL NOT truncate the frame; it is sampled only at the end of VFP.
REQ-026 Default pattern: R=col[7:4], G=row[6:3], B=col[3:0] (col 0..WC-1, row 0..WR-1).
REQ-027 Column and row counters SHALL be wide enough for WC and WR (min 8 and 7 bits); they SHALL NOT wrap within a frame.
REQ-028 CAM_px_data SHALL be 8'h00 whenever CAM_href=0.

Reset
REQ-029 While rst=1: state=IDLE, CAM_pclk=0, CAM_vsync=0, CAM_href=0, CAM_px_data=8'h00, frame_done=0, all counters 0.
REQ-030 Reset asserted mid-line or mid-frame SHALL abort immediately; after release, generation restarts with a full VSYNC.

Configuration
REQ-031 Macro CAM_EMU_COLORBAR_EN, when defined, SHALL replace the pattern with 8 vertical bars, each WC/8 columns wide: FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000 (RGB444).
REQ-032 Without CAM_EMU_COLORBAR_EN, the gradient pattern of REQ-026 SHALL be used and no bar logic SHALL be synthesized.

Verification
REQ-033 rst=1 then release with enable=0 for 100 clk -> vsync/href/px_data stay 0, pclk toggles every clk.
REQ-034 enable=1 -> vsync high for 3 pclk periods, then 17 idle periods, then first href rise; count 120 href pulses of 320 pclk rising edges each per frame, one frame_done pulse.
REQ-035 Default build, row 8, col 17 -> sampled bytes 8'h01 then 8'h11; row 0, col 0 -> 8'h00, 8'h00.
REQ-036 CAM_EMU_COLORBAR_EN defined, any row -> col 0 bytes 8'h0F, 8'hFF; col 20 bytes 8'h0F, 8'hF0; col 159 bytes 8'h00, 8'h00.
REQ-037 Drop enable during row 50 -> frame completes through row 119 and VFP, then IDLE with vsync low.
REQ-038 Assert rst during ACTIVE of row 10 -> all outputs 0 on the same clk edge; after release with enable=1 -> new frame begins with VSYNC.
